// File: rtl/reg_read_stage_pkg.sv
// Shared types and default sizing for the register-read stage (package rr_pkg).
package rr_pkg;

  localparam int unsigned DEF_DATA_W    = 64;
  localparam int unsigned DEF_NUM_REGS  = 16;
  localparam int unsigned DEF_NUM_SRC   = 2;
  localparam int unsigned DEF_PAYLOAD_W = 256;
  localparam int unsigned DEF_REG_W     = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_REG_W-1:0]  reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] operand_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/reg_read_stage_if.sv
// Decode-side and execute-side handshake bundle for reg_read_stage.
interface reg_read_stage_if
  import rr_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned NUM_SRC   = DEF_NUM_SRC,
  parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W
);
  localparam int unsigned REG_W = $clog2(NUM_REGS);

  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_SRC-1:0][REG_W-1:0]     in_src_reg;
  logic [NUM_SRC-1:0]                in_src_valid;
  logic [REG_W-1:0]                  in_dest_reg;
  logic                              in_dest_valid;
  logic [PAYLOAD_W-1:0]              in_payload;

  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_SRC-1:0][DATA_W-1:0]    out_operand;
  logic [NUM_SRC-1:0][REG_W-1:0]     out_src_reg;
  logic [NUM_SRC-1:0]                out_src_valid;
  logic [REG_W-1:0]                  out_dest_reg;
  logic                              out_dest_valid;
  logic [PAYLOAD_W-1:0]              out_payload;

  modport master (
    output in_valid, in_src_reg, in_src_valid, in_dest_reg, in_dest_valid, in_payload, out_ready,
    input  in_ready, out_valid, out_operand, out_src_reg, out_src_valid, out_dest_reg,
           out_dest_valid, out_payload
  );

  modport slave (
    input  in_valid, in_src_reg, in_src_valid, in_dest_reg, in_dest_valid, in_payload, out_ready,
    output in_ready, out_valid, out_operand, out_src_reg, out_src_valid, out_dest_reg,
           out_dest_valid, out_payload
  );
endinterface

// File: rtl/reg_read_stage_scoreboard.sv
// Busy-register scoreboard: set on issue to execute, clear on writeback (set wins),
// plus per-query busy and writeback-match lookups.
module rr_scoreboard
  import rr_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_Q    = DEF_NUM_SRC + 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   set_en,
  input  logic [$clog2(NUM_REGS)-1:0]            set_reg,
  input  logic                                   wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]            wb_reg,
  input  logic [NUM_Q-1:0][$clog2(NUM_REGS)-1:0] q_reg,
  output logic [NUM_Q-1:0]                       q_busy,
  output logic [NUM_Q-1:0]                       q_wb_hit,
  output logic [NUM_REGS-1:0]                    busy
);
  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (wb_valid) busy_next[wb_reg] = 1'b0;
    if (set_en)   busy_next[set_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

  always_comb begin
    q_busy   = '0;
    q_wb_hit = '0;
    for (int unsigned q = 0; q < NUM_Q; q++) begin
      q_busy[q]   = busy[q_reg[q]];
      q_wb_hit[q] = wb_valid && (wb_reg == q_reg[q]);
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: hazard-checked issue, operand read, registered output.
// Optional writeback bypass enabled by defining REG_READ_BYPASS_EN.
module reg_read_stage
  import rr_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned NUM_SRC   = DEF_NUM_SRC,
  parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  reg_read_stage_if.slave                  io,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  reg_file,
  input  logic                             wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]      wb_reg,
  input  logic [DATA_W-1:0]                wb_data,
  output logic [NUM_REGS-1:0]              busy,
  output logic [31:0]                      stall_count
);
  localparam int unsigned REG_W = $clog2(NUM_REGS);
  localparam int unsigned NUM_Q = NUM_SRC + 1;

  logic                           out_valid_q;
  logic [NUM_SRC-1:0][DATA_W-1:0] out_operand_q;
  logic [NUM_SRC-1:0][REG_W-1:0]  out_src_reg_q;
  logic [NUM_SRC-1:0]             out_src_valid_q;
  logic [REG_W-1:0]               out_dest_reg_q;
  logic                           out_dest_valid_q;
  logic [PAYLOAD_W-1:0]           out_payload_q;

  logic [NUM_Q-1:0][REG_W-1:0]    q_reg;
  logic [NUM_Q-1:0]               q_used;
  logic [NUM_Q-1:0]               q_busy;
  logic [NUM_Q-1:0]               q_wb_hit;
  logic [NUM_SRC-1:0][DATA_W-1:0] next_operand;
  logic                           hazard;
  logic                           in_ready;
  logic                           accept;
  logic                           leave;

  // Queries 0..NUM_SRC-1 are the sources, the last one is the destination.
  always_comb begin
    q_reg  = '0;
    q_used = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      q_reg[s]  = io.in_src_reg[s];
      q_used[s] = io.in_src_valid[s];
    end
    q_reg[NUM_SRC]  = io.in_dest_reg;
    q_used[NUM_SRC] = io.in_dest_valid;
  end

  rr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_Q    (NUM_Q)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (leave && out_dest_valid_q),
    .set_reg  (out_dest_reg_q),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .q_reg    (q_reg),
    .q_busy   (q_busy),
    .q_wb_hit (q_wb_hit),
    .busy     (busy)
  );

  // The held instruction is not yet in the scoreboard, so it is checked separately.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    hazard  = 1'b0;
    for (int unsigned q = 0; q < NUM_Q; q++) begin
`ifdef REG_READ_BYPASS_EN
      blocked = q_busy[q] && !q_wb_hit[q];
`else
      blocked = q_busy[q];
`endif
      if (q_used[q] && (blocked ||
          (out_valid_q && out_dest_valid_q && (out_dest_reg_q == q_reg[q]))))
        hazard = 1'b1;
    end
  end

  always_comb begin
    next_operand = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (io.in_src_valid[s]) begin
`ifdef REG_READ_BYPASS_EN
        next_operand[s] = q_wb_hit[s] ? wb_data : reg_file[io.in_src_reg[s]];
`else
        next_operand[s] = reg_file[io.in_src_reg[s]];
`endif
      end
    end
  end

`ifndef REG_READ_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wb_data, q_wb_hit};
`endif

  assign in_ready = !hazard && (!out_valid_q || io.out_ready) && !flush;
  assign accept   = io.in_valid && in_ready;
  assign leave    = out_valid_q && io.out_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q      <= 1'b0;
      out_operand_q    <= '0;
      out_src_reg_q    <= '0;
      out_src_valid_q  <= '0;
      out_dest_reg_q   <= '0;
      out_dest_valid_q <= 1'b0;
      out_payload_q    <= '0;
    end else if (accept) begin
      out_valid_q      <= 1'b1;
      out_operand_q    <= next_operand;
      out_src_reg_q    <= io.in_src_reg;
      out_src_valid_q  <= io.in_src_valid;
      out_dest_reg_q   <= io.in_dest_reg;
      out_dest_valid_q <= io.in_dest_valid;
      out_payload_q    <= io.in_payload;
    end else if (flush || (out_valid_q && io.out_ready)) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    stall_count <= '0;
    else if (io.in_valid && hazard)  stall_count <= sat_inc32(stall_count);
  end

  assign io.in_ready       = in_ready;
  assign io.out_valid      = out_valid_q;
  assign io.out_operand    = out_operand_q;
  assign io.out_src_reg    = out_src_reg_q;
  assign io.out_src_valid  = out_src_valid_q;
  assign io.out_dest_reg   = out_dest_reg_q;
  assign io.out_dest_valid = out_dest_valid_q;
  assign io.out_payload    = out_payload_q;

endmodule

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Parametrised register-read pipeline stage with valid/ready handshakes on both sides.
- Sits between decode and execute. Reads up to NUM_SRC source operands from the architectural register file and forwards the decoded payload.
- Tracks in-flight writers in a scoreboard and stalls on hazards.
- Registers its outputs (1-cycle latency) and supports flush.

Parameters:
- DATA_W, 64, operand/register width
- NUM_REGS, 16, architectural register count
- NUM_SRC, 2, source operands per instruction
- PAYLOAD_W, 256, opaque pass-through decode fields (rip, opcode, imm, disp…)
- REG_W, $clog2(NUM_REGS), register index width (derived, not overridden)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  discard held instruction
- in_valid  in  1  decode offers instruction
- in_ready  out  1  stage accepts this cycle
- in_src_reg  in  NUM_SRC×REG_W  source indices
- in_src_valid  in  NUM_SRC  source used
- in_dest_reg  in  REG_W  destination index
- in_dest_valid  in  1  destination written
- in_payload  in  PAYLOAD_W  pass-through fields
- reg_file  in  NUM_REGS×DATA_W  architectural register values
- wb_valid  in  1  writeback this cycle
- wb_reg  in  REG_W  writeback index
- wb_data  in  DATA_W  writeback value
- out_valid  out  1  instruction held for execute
- out_ready  in  1  execute accepts
- out_operand  out  NUM_SRC×DATA_W  operand values
- out_src_reg / out_src_valid  out  NUM_SRC×REG_W / NUM_SRC  registered copies of the source fields
- out_dest_reg / out_dest_valid  out  REG_W / 1  registered copies of the destination fields
- out_payload  out  PAYLOAD_W  registered copy of the payload
- busy  out  NUM_REGS  scoreboard
- stall_count  out  32  hazard-stall cycle counter

Behaviour:
- Reset (async, reset_n=0) clears:
  - out_valid, busy, stall_count.
  - all out_* data fields to 0.
- Source s is hazarded when in_src_valid[s] and either:
  - busy[src] and not (wb_valid && wb_reg==src), or
  - out_valid && out_dest_valid && out_dest_reg==src.
- Destination is hazarded (WAW) under the same rules on in_dest_reg when in_dest_valid.
- hazard = any source hazard or destination hazard.
- Issue handshake:
  - in_ready = !hazard && (!out_valid || out_ready) && !flush.
  - Accept = in_valid && in_ready. On accept, next edge: out_valid=1 and all out_* fields are loaded.
- Operand selection per source:
  - wb_data when wb_valid && wb_reg==src.
  - else reg_file[src].
  - 0 when !in_src_valid[s].
- Leaving the output register:
  - out_valid && out_ready with no simultaneous accept → out_valid=0.
  - Leave and accept in the same cycle are allowed (back-to-back throughput of 1 per cycle).
- Scoreboard:
  - On output handshake with out_dest_valid → set busy[out_dest_reg].
  - On wb_valid → clear busy[wb_reg].
  - Set and clear of the same register in one cycle: set wins.
- Flush:
  - Next edge: out_valid=0; the held instruction never sets busy.
  - Flush has priority over out_ready.
  - in_ready=0 during the flush cycle.
  - busy is not cleared by flush; outstanding writers still write back.
- stall_count:
  - Increments when in_valid && hazard.
  - Saturates at 0xFFFF_FFFF.
- Output data fields hold their values while out_valid=0 (no toggling); consumers qualify on out_valid.
- Back-pressure: out_valid && !out_ready holds every out_* field stable.

Optional Feature:
- Macro: REG_READ_BYPASS_EN.
- Defined: writeback-to-read bypass as above; a matching wb clears the hazard in the same cycle.
- Undefined:
  - No bypass path; operands always come from reg_file.
  - A busy source stays hazarded during its wb cycle and issues the following cycle, after the register file updates.
  - stall_count counts that extra cycle.

Decomposition:
- Shared package rr_pkg holds the reg_idx_t typedef (REG_W), the operand_t typedef (DATA_W), and the default constants.
- One sub-module: rr_scoreboard. It owns the busy vector and the set/clear priority, and provides the per-index busy and wb-match lookup.
- The top level holds the handshake, operand mux and output register.

Test Plan:
1. Reset: assert reset_n=0 mid-transfer with out_valid=1 → out_valid=0, busy=0, stall_count=0 immediately (asynchronous).
2. Simple issue: r3=0x1111, r5=0x2222, in src {3,5}, dest 7 → next cycle out_operand={0x1111,0x2222}, out_valid=1; after out_ready, busy[7]=1.
3. RAW stall: busy[7]=1, in src0=7 → in_ready=0 and stall_count increments each cycle.
   - wb_valid on r7 with data 0xABCD: with REG_READ_BYPASS_EN, same-cycle accept and operand=0xABCD.
   - without it: accept one cycle later, operand taken from reg_file.
4. Back-pressure: out_ready=0 for 3 cycles → out_* stable and in_ready=0; then out_ready=1 with in_valid=1 → leave and accept in the same cycle.
5. Flush: held instruction with dest 4, flush=1 and out_ready=1 → out_valid=0, busy[4] stays 0.
6. Collision: wb_valid on r2 in the same cycle the leaving instruction has dest 2 → busy[2]=1 (set wins).
